// File: rtl/rob_cmt.sv
// In-order reorder/commit buffer: allocates entries at dispatch, marks them done on untagged
// per-unit completions, and retires the head entry to the GPR file one per cycle.
module rob_cmt #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = $clog2(DEPTH),
    parameter int unsigned XLEN  = 64
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             ctrl_rob_flush,
    input  logic             disp_rob_vld,
    input  logic [1:0]       disp_rob_unit,
    input  logic [4:0]       disp_rob_rd,
    input  logic             disp_rob_wen,
    output logic             rob_disp_rdy,
    output logic [PTR_W-1:0] rob_disp_tag,
    input  logic             wb_rob_alu_gpr_vld,
    input  logic             wb_rob_alu_gpr_fake_vld,
    input  logic [XLEN-1:0]  wb_rob_alu_gpr_wdata,
    input  logic             wb_rob_mul_vld,
    input  logic             wb_rob_mul_fake_vld,
    input  logic [XLEN-1:0]  wb_rob_mul_wdata,
    input  logic             wb_rob_div_vld,
    input  logic             wb_rob_div_fake_vld,
    input  logic [XLEN-1:0]  wb_rob_div_wdata,
    input  logic             wb_rob_lsu_vld,
    input  logic             wb_rob_lsu_wen,
    input  logic [XLEN-1:0]  wb_rob_lsu_wdata,
    input  logic             wb_rob_load_fake_vld,
    input  logic             wb_rob_lsu_store_cmt_vld,
    output logic             rob_cmt_vld,
    output logic             rob_gpr_wen,
    output logic [4:0]       rob_gpr_waddr,
    output logic [XLEN-1:0]  rob_gpr_wdata,
    output logic             rob_cpl_err
);

    localparam int unsigned NUM_UNITS = 4;

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] done_q;
    logic [DEPTH-1:0] wen_q;
    logic [1:0]       unit_q [DEPTH];
    logic [4:0]       rd_q   [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W:0]   cnt_q;

    logic [NUM_UNITS-1:0] cmp_evt;
    logic [NUM_UNITS-1:0] cmp_real;
    logic [XLEN-1:0]      cmp_data [NUM_UNITS];
    logic [NUM_UNITS-1:0] cmp_hit;
    logic [PTR_W-1:0]     cmp_idx  [NUM_UNITS];
    logic [PTR_W-1:0]     scan_idx;

    logic disp_fire;
    logic retire;

    assign rob_disp_rdy = (cnt_q < (PTR_W + 1)'(DEPTH));
    assign rob_disp_tag = tail_q;
    assign disp_fire    = disp_rob_vld & rob_disp_rdy;
    assign retire       = vld_q[head_q] & done_q[head_q];

    // One event per unit; an LSU load without wen only marks the entry done.
    always_comb begin
        cmp_evt[0]  = wb_rob_alu_gpr_vld | wb_rob_alu_gpr_fake_vld;
        cmp_real[0] = wb_rob_alu_gpr_vld;
        cmp_data[0] = wb_rob_alu_gpr_wdata;
        cmp_evt[1]  = wb_rob_mul_vld | wb_rob_mul_fake_vld;
        cmp_real[1] = wb_rob_mul_vld;
        cmp_data[1] = wb_rob_mul_wdata;
        cmp_evt[2]  = wb_rob_div_vld | wb_rob_div_fake_vld;
        cmp_real[2] = wb_rob_div_vld;
        cmp_data[2] = wb_rob_div_wdata;
        cmp_evt[3]  = wb_rob_lsu_vld | wb_rob_load_fake_vld | wb_rob_lsu_store_cmt_vld;
        cmp_real[3] = wb_rob_lsu_vld & wb_rob_lsu_wen;
        cmp_data[3] = wb_rob_lsu_wdata;
    end

    // Oldest-first scan from head for the first pending entry of each unit.
    always_comb begin
        scan_idx = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            cmp_hit[u] = 1'b0;
            cmp_idx[u] = '0;
        end
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_q + PTR_W'(k);
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (!cmp_hit[u] && vld_q[scan_idx] && !done_q[scan_idx] &&
                    (unit_q[scan_idx] == 2'(u))) begin
                    cmp_hit[u] = 1'b1;
                    cmp_idx[u] = scan_idx;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_q         <= '0;
            done_q        <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            cnt_q         <= '0;
            rob_cmt_vld   <= 1'b0;
            rob_gpr_wen   <= 1'b0;
            rob_gpr_waddr <= '0;
            rob_gpr_wdata <= '0;
            rob_cpl_err   <= 1'b0;
        end else if (ctrl_rob_flush) begin
            vld_q       <= '0;
            done_q      <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            rob_cmt_vld <= 1'b0;
            rob_gpr_wen <= 1'b0;
        end else begin
            // Completion targets are never the retiring head (done) nor the tail slot (free).
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (cmp_evt[u]) begin
                    if (cmp_hit[u]) begin
                        done_q[cmp_idx[u]] <= 1'b1;
                        if (cmp_real[u]) begin
                            data_q[cmp_idx[u]] <= cmp_data[u];
                        end else begin
                            wen_q[cmp_idx[u]] <= 1'b0;
                        end
                    end else begin
                        rob_cpl_err <= 1'b1;
                    end
                end
            end

            rob_cmt_vld <= retire;
            rob_gpr_wen <= retire & wen_q[head_q] & (rd_q[head_q] != 5'd0);
            if (retire) begin
                vld_q[head_q]  <= 1'b0;
                done_q[head_q] <= 1'b0;
                rob_gpr_waddr  <= rd_q[head_q];
                rob_gpr_wdata  <= data_q[head_q];
            end

            // Data starts at zero so a fake-completed entry retires a defined value.
            if (disp_fire) begin
                vld_q[tail_q]  <= 1'b1;
                done_q[tail_q] <= 1'b0;
                unit_q[tail_q] <= disp_rob_unit;
                rd_q[tail_q]   <= disp_rob_rd;
                wen_q[tail_q]  <= disp_rob_wen;
                data_q[tail_q] <= '0;
            end

            head_q <= head_q + PTR_W'(retire);
            tail_q <= tail_q + PTR_W'(disp_fire);
            cnt_q  <= cnt_q + (PTR_W + 1)'(disp_fire) - (PTR_W + 1)'(retire);
        end
    end

endmodule

// File: tb/tb_rob_cmt.sv
// Bench for rob_cmt: directed vector table, hand sequences for multi-cycle corners, and a
// randomized run against a queue-based model of the commit buffer.
module tb_rob_cmt;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ctrl_rob_flush;
    logic        disp_rob_vld;
    logic [1:0]  disp_rob_unit;
    logic [4:0]  disp_rob_rd;
    logic        disp_rob_wen;
    logic        rob_disp_rdy;
    logic [2:0]  rob_disp_tag;
    logic        alu_v, alu_f, mul_v, mul_f, div_v, div_f;
    logic [63:0] alu_d, mul_d, div_d, lsu_d;
    logic        lsu_v, lsu_wen, ld_fake, st_cmt;
    logic        rob_cmt_vld;
    logic        rob_gpr_wen;
    logic [4:0]  rob_gpr_waddr;
    logic [63:0] rob_gpr_wdata;
    logic        rob_cpl_err;

    int checks = 0;
    int errors = 0;

    rob_cmt #(.DEPTH(8), .PTR_W(3), .XLEN(64)) dut (
        .clk                      (clk),
        .rstn                     (rstn),
        .ctrl_rob_flush           (ctrl_rob_flush),
        .disp_rob_vld             (disp_rob_vld),
        .disp_rob_unit            (disp_rob_unit),
        .disp_rob_rd              (disp_rob_rd),
        .disp_rob_wen             (disp_rob_wen),
        .rob_disp_rdy             (rob_disp_rdy),
        .rob_disp_tag             (rob_disp_tag),
        .wb_rob_alu_gpr_vld       (alu_v),
        .wb_rob_alu_gpr_fake_vld  (alu_f),
        .wb_rob_alu_gpr_wdata     (alu_d),
        .wb_rob_mul_vld           (mul_v),
        .wb_rob_mul_fake_vld      (mul_f),
        .wb_rob_mul_wdata         (mul_d),
        .wb_rob_div_vld           (div_v),
        .wb_rob_div_fake_vld      (div_f),
        .wb_rob_div_wdata         (div_d),
        .wb_rob_lsu_vld           (lsu_v),
        .wb_rob_lsu_wen           (lsu_wen),
        .wb_rob_lsu_wdata         (lsu_d),
        .wb_rob_load_fake_vld     (ld_fake),
        .wb_rob_lsu_store_cmt_vld (st_cmt),
        .rob_cmt_vld              (rob_cmt_vld),
        .rob_gpr_wen              (rob_gpr_wen),
        .rob_gpr_waddr            (rob_gpr_waddr),
        .rob_gpr_wdata            (rob_gpr_wdata),
        .rob_cpl_err              (rob_cpl_err)
    );

    always #5 clk = ~clk;

    // Reference model: program-ordered list of in-flight instructions.
    typedef struct {
        logic [1:0]  unit;
        logic [4:0]  rd;
        logic        wen;
        logic        done;
        logic [63:0] data;
    } ent_t;

    ent_t        mq[$];
    int          m_tail;
    logic        e_cmt, e_gwen, e_err;
    logic [4:0]  e_waddr;
    logic [63:0] e_wdata;

    function automatic int find_pending(input int u);
        for (int i = 0; i < mq.size(); i++)
            if (!mq[i].done && mq[i].unit == 2'(u)) return i;
        return -1;
    endfunction

    function automatic void m_complete(input int u, input bit real_c, input bit fake_c,
                                       input logic [63:0] d);
        int i;
        if (!(real_c || fake_c)) return;
        i = find_pending(u);
        if (i < 0) begin
            e_err = 1'b1;
            return;
        end
        mq[i].done = 1'b1;
        if (real_c) mq[i].data = d;
        else mq[i].wen = 1'b0;
    endfunction

    function automatic void model_step();
        bit   rdy, ret;
        ent_t h;
        ent_t n;
        if (!rstn) begin
            mq.delete();
            m_tail = 0; e_cmt = 0; e_gwen = 0; e_waddr = '0; e_wdata = '0; e_err = 0;
            return;
        end
        if (ctrl_rob_flush) begin
            mq.delete();
            m_tail = 0; e_cmt = 0; e_gwen = 0;
            return;
        end
        rdy = (mq.size() < DEPTH);
        ret = (mq.size() > 0) && mq[0].done;
        m_complete(0, alu_v, alu_f, alu_d);
        m_complete(1, mul_v, mul_f, mul_d);
        m_complete(2, div_v, div_f, div_d);
        if (lsu_v)        m_complete(3, lsu_wen, !lsu_wen, lsu_d);
        else if (ld_fake) m_complete(3, 1'b0, 1'b1, '0);
        else if (st_cmt)  m_complete(3, 1'b0, 1'b1, '0);
        if (ret) begin
            h = mq.pop_front();
            e_cmt = 1; e_gwen = h.wen && (h.rd != 0); e_waddr = h.rd; e_wdata = h.data;
        end else begin
            e_cmt = 0; e_gwen = 0;
        end
        if (disp_rob_vld && rdy) begin
            n.unit = disp_rob_unit; n.rd = disp_rob_rd; n.wen = disp_rob_wen;
            n.done = 1'b0; n.data = '0;
            mq.push_back(n);
            m_tail = (m_tail + 1) % DEPTH;
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        ctrl_rob_flush = 0; disp_rob_vld = 0; disp_rob_unit = 0; disp_rob_rd = 0;
        disp_rob_wen = 0;
        alu_v = 0; alu_f = 0; alu_d = 0; mul_v = 0; mul_f = 0; mul_d = 0;
        div_v = 0; div_f = 0; div_d = 0;
        lsu_v = 0; lsu_wen = 0; lsu_d = 0; ld_fake = 0; st_cmt = 0;
    endtask

    // Apply current inputs for one clock, then compare every output with the model.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("rdy", 64'(rob_disp_rdy), 64'(mq.size() < DEPTH));
        chk("tag", 64'(rob_disp_tag), 64'(m_tail));
        chk("cmt_vld", 64'(rob_cmt_vld), 64'(e_cmt));
        chk("gpr_wen", 64'(rob_gpr_wen), 64'(e_gwen));
        chk("waddr", 64'(rob_gpr_waddr), 64'(e_waddr));
        chk("wdata", rob_gpr_wdata, e_wdata);
        chk("cpl_err", 64'(rob_cpl_err), 64'(e_err));
        idle_inputs();
    endtask

    task automatic disp(input logic [1:0] u, input logic [4:0] rd, input logic wen);
        disp_rob_vld = 1; disp_rob_unit = u; disp_rob_rd = rd; disp_rob_wen = wen;
    endtask

    task automatic do_reset();
        rstn = 0;
        cycle();
        cycle();
        rstn = 1;
    endtask

    typedef struct {
        logic flush; logic dv; logic [1:0] du; logic [4:0] drd; logic dwen;
        logic av; logic af; logic [63:0] ad; logic mv; logic mf;
        logic e_cmt; logic e_gwen; logic [4:0] e_waddr; logic [63:0] e_wdata;
        logic e_rdy; logic [2:0] e_tag;
    } vec_t;

    vec_t vt[9];

    initial begin
        vt[0] = '{0, 1, 2'd0, 5'd5, 1, 0, 0, 64'h0,    0, 0, 0, 0, 5'd0, 64'h0,    1, 3'd1};
        vt[1] = '{0, 0, 2'd0, 5'd0, 0, 1, 0, 64'h1234, 0, 0, 0, 0, 5'd0, 64'h0,    1, 3'd1};
        vt[2] = '{0, 0, 2'd0, 5'd0, 0, 0, 0, 64'h0,    0, 0, 1, 1, 5'd5, 64'h1234, 1, 3'd1};
        vt[3] = '{0, 0, 2'd0, 5'd0, 0, 0, 0, 64'h0,    0, 0, 0, 0, 5'd5, 64'h1234, 1, 3'd1};
        vt[4] = '{0, 1, 2'd0, 5'd0, 1, 0, 0, 64'h0,    0, 0, 0, 0, 5'd5, 64'h1234, 1, 3'd2};
        vt[5] = '{0, 1, 2'd1, 5'd7, 1, 1, 0, 64'hAA,   0, 0, 0, 0, 5'd5, 64'h1234, 1, 3'd3};
        vt[6] = '{0, 0, 2'd0, 5'd0, 0, 0, 0, 64'h0,    0, 1, 1, 0, 5'd0, 64'hAA,   1, 3'd3};
        vt[7] = '{0, 0, 2'd0, 5'd0, 0, 0, 0, 64'h0,    0, 0, 1, 0, 5'd7, 64'h0,    1, 3'd3};
        vt[8] = '{0, 0, 2'd0, 5'd0, 0, 0, 0, 64'h0,    0, 0, 0, 0, 5'd7, 64'h0,    1, 3'd3};

        idle_inputs();
        do_reset();
        chk("reset_rdy", 64'(rob_disp_rdy), 64'd1);
        chk("reset_tag", 64'(rob_disp_tag), 64'd0);
        chk("reset_cmt", 64'(rob_cmt_vld), 64'd0);
        chk("reset_gwen", 64'(rob_gpr_wen), 64'd0);
        chk("reset_waddr", 64'(rob_gpr_waddr), 64'd0);
        chk("reset_wdata", rob_gpr_wdata, 64'd0);
        chk("reset_err", 64'(rob_cpl_err), 64'd0);

        // ALU retire latency, then rd=0 real and MUL fake retire without a GPR write.
        for (int i = 0; i < 9; i++) begin
            ctrl_rob_flush = vt[i].flush;
            disp_rob_vld = vt[i].dv; disp_rob_unit = vt[i].du;
            disp_rob_rd = vt[i].drd; disp_rob_wen = vt[i].dwen;
            alu_v = vt[i].av; alu_f = vt[i].af; alu_d = vt[i].ad;
            mul_v = vt[i].mv; mul_f = vt[i].mf;
            cycle();
            chk($sformatf("vec%0d_cmt", i), 64'(rob_cmt_vld), 64'(vt[i].e_cmt));
            chk($sformatf("vec%0d_gwen", i), 64'(rob_gpr_wen), 64'(vt[i].e_gwen));
            chk($sformatf("vec%0d_waddr", i), 64'(rob_gpr_waddr), 64'(vt[i].e_waddr));
            chk($sformatf("vec%0d_wdata", i), rob_gpr_wdata, vt[i].e_wdata);
            chk($sformatf("vec%0d_rdy", i), 64'(rob_disp_rdy), 64'(vt[i].e_rdy));
            chk($sformatf("vec%0d_tag", i), 64'(rob_disp_tag), 64'(vt[i].e_tag));
        end

        // Younger ALU completes first; nothing retires until the older DIV is done.
        disp(2'd2, 5'd3, 1); cycle();
        disp(2'd0, 5'd4, 1); cycle();
        alu_v = 1; alu_d = 64'h44; cycle();
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("div_block", 64'(rob_cmt_vld), 64'd0);
        end
        div_v = 1; div_d = 64'h33; cycle();
        chk("div_cpl_nocmt", 64'(rob_cmt_vld), 64'd0);
        cycle();
        chk("div_ret_vld", 64'(rob_cmt_vld), 64'd1);
        chk("div_ret_rd", 64'(rob_gpr_waddr), 64'd3);
        chk("div_ret_data", rob_gpr_wdata, 64'h33);
        cycle();
        chk("alu_ret_vld", 64'(rob_cmt_vld), 64'd1);
        chk("alu_ret_rd", 64'(rob_gpr_waddr), 64'd4);
        chk("alu_ret_data", rob_gpr_wdata, 64'h44);

        // Full buffer: not ready through the retire cycle, then wrap to tag 0.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            disp(2'd0, 5'(i + 1), 1); cycle();
        end
        chk("full_rdy", 64'(rob_disp_rdy), 64'd0);
        chk("full_tag", 64'(rob_disp_tag), 64'd0);
        disp(2'd0, 5'd9, 1); alu_v = 1; alu_d = 64'h77; cycle();
        chk("full_cpl_rdy", 64'(rob_disp_rdy), 64'd0);
        disp(2'd0, 5'd9, 1); cycle();
        chk("full_ret_cmt", 64'(rob_cmt_vld), 64'd1);
        chk("full_ret_rd", 64'(rob_gpr_waddr), 64'd1);
        chk("full_ret_rdy", 64'(rob_disp_rdy), 64'd1);
        chk("full_ret_tag", 64'(rob_disp_tag), 64'd0);
        disp(2'd0, 5'd9, 1); cycle();
        chk("wrap_rdy", 64'(rob_disp_rdy), 64'd0);
        chk("wrap_tag", 64'(rob_disp_tag), 64'd1);

        // Four units complete together; retires follow one per cycle in order.
        do_reset();
        for (int u = 0; u < 4; u++) begin
            disp(2'(u), 5'(u + 1), 1); cycle();
        end
        alu_v = 1; alu_d = 64'h11; mul_v = 1; mul_d = 64'h22;
        div_v = 1; div_d = 64'h33; st_cmt = 1;
        cycle();
        chk("quad_nocmt", 64'(rob_cmt_vld), 64'd0);
        for (int u = 0; u < 4; u++) begin
            cycle();
            chk($sformatf("quad%0d_cmt", u), 64'(rob_cmt_vld), 64'd1);
            chk($sformatf("quad%0d_rd", u), 64'(rob_gpr_waddr), 64'(u + 1));
            chk($sformatf("quad%0d_gwen", u), 64'(rob_gpr_wen), 64'(u != 3));
        end
        mul_v = 1; mul_d = 64'h5; cycle();
        chk("err_set", 64'(rob_cpl_err), 64'd1);
        cycle(); cycle();
        chk("err_sticky", 64'(rob_cpl_err), 64'd1);

        // Flush with live entries, a pending head retire and a same-cycle dispatch.
        for (int i = 0; i < 5; i++) begin
            disp(2'd0, 5'(i + 1), 1);
            if (i == 4) begin
                alu_v = 1; alu_d = 64'h99;
            end
            cycle();
        end
        ctrl_rob_flush = 1; disp(2'd1, 5'd6, 1); cycle();
        chk("flush_rdy", 64'(rob_disp_rdy), 64'd1);
        chk("flush_tag", 64'(rob_disp_tag), 64'd0);
        chk("flush_cmt", 64'(rob_cmt_vld), 64'd0);
        chk("flush_err", 64'(rob_cpl_err), 64'd1);
        cycle();
        chk("flush_after_cmt", 64'(rob_cmt_vld), 64'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rstn = ($urandom_range(0, 299) != 0);
            ctrl_rob_flush = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 9) < 6) disp(2'($urandom_range(0, 3)), 5'($urandom), 1'($urandom));
            for (int u = 0; u < 3; u++) begin
                logic rv, fv;
                int   sel;
                sel = $urandom_range(0, 2);
                rv = (sel != 1); fv = (sel != 0);
                if ((find_pending(u) >= 0 && $urandom_range(0, 9) < 4) ||
                    (find_pending(u) < 0 && !ctrl_rob_flush && $urandom_range(0, 199) == 0)) begin
                    case (u)
                        0: begin alu_v = rv; alu_f = fv; alu_d = {$urandom, $urandom}; end
                        1: begin mul_v = rv; mul_f = fv; mul_d = {$urandom, $urandom}; end
                        default: begin div_v = rv; div_f = fv; div_d = {$urandom, $urandom}; end
                    endcase
                end
            end
            if (find_pending(3) >= 0 && $urandom_range(0, 9) < 4) begin
                lsu_v = 1'($urandom); lsu_wen = 1'($urandom); lsu_d = {$urandom, $urandom};
                ld_fake = 1'($urandom); st_cmt = 1'($urandom);
                if (!lsu_v && !ld_fake) st_cmt = 1;
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
